// File: rtl/register_write_scheduler.sv
// Queues SPI register writes (one per strobe rising edge) and dispatches each to one of four targets.
// Latency: strobe edge to target write is 3 cycles with the target ready; one dispatch every 2 cycles.
// Backpressure: head entry waits for its target's window or times out; pushes into a full queue are dropped and flagged.

module sync_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 8
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset,
  input  logic                     wr_vld,
  output logic                     wr_rdy,
  input  logic [WIDTH-1:0]         wr_dat,
  output logic                     rd_vld,
  input  logic                     rd_rdy,
  output logic [WIDTH-1:0]         rd_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_fire;
  logic             rd_fire;

  // Fullness is judged on the pre-pop count, so a push into a full queue is
  // dropped even when a pop happens in the same cycle.
  assign wr_rdy  = (count != CW'(DEPTH));
  assign rd_vld  = (count != '0);
  assign wr_fire = wr_vld && wr_rdy;
  assign rd_fire = rd_rdy && rd_vld;
  assign rd_dat  = mem[rd_ptr];

  always_ff @(posedge i_Clock) begin
    if (wr_fire) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module register_write_scheduler #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_WriteEnable,
  input  logic [14:0]                   i_WriteNumber,
  input  logic [15:0]                   i_WriteValue,
  input  logic [3:0]                    i_TargetReady,
  input  logic                          i_ClearFlags,
  output logic [3:0]                    o_TargetWriteEnable,
  output logic [12:0]                   o_TargetAddress,
  output logic [15:0]                   o_TargetValue,
  output logic [$clog2(FIFO_DEPTH):0]   o_FifoCount,
  output logic                          o_Overflow,
  output logic                          o_Timeout,
  output logic                          o_Busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef struct packed {
    logic [14:0] number;
    logic [15:0] value;
  } entry_t;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  entry_t          hold_q;
  entry_t          fifo_wr_dat;
  logic [$bits(entry_t)-1:0] fifo_rd_dat;
  logic            we_last_q;
  logic            push_req;
  logic            fifo_wr_rdy;
  logic            fifo_rd_vld;
  logic            fifo_pop;
  logic            dispatch;
  logic            timeout_evt;
  logic [3:0]      strobe_d;
  logic [1:0]      sel;

  assign push_req    = i_WriteEnable && !we_last_q;
  assign fifo_wr_dat = '{number: i_WriteNumber, value: i_WriteValue};
  assign sel         = hold_q.number[14:13];

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .wr_vld  (push_req),
    .wr_rdy  (fifo_wr_rdy),
    .wr_dat  (fifo_wr_dat),
    .rd_vld  (fifo_rd_vld),
    .rd_rdy  (fifo_pop),
    .rd_dat  (fifo_rd_dat),
    .count   (o_FifoCount)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fifo_pop    = 1'b0;
    dispatch    = 1'b0;
    timeout_evt = 1'b0;
    strobe_d    = 4'b0000;
    case (state_q)
      IDLE: begin
        if (fifo_rd_vld) begin
          fifo_pop = 1'b1;
          cnt_d    = '0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        // Only the head's own target matters; other ready lines never reorder.
        if (i_TargetReady[sel]) begin
          strobe_d = 4'b0001 << sel;
          dispatch = 1'b1;
          state_d  = IDLE;
        end else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_evt = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    // Track the strobe level through reset so a level held across reset is not captured.
    we_last_q <= i_WriteEnable;
    if (i_Reset) begin
      state_q             <= IDLE;
      cnt_q               <= '0;
      hold_q              <= '0;
      o_TargetWriteEnable <= 4'b0000;
      o_TargetAddress     <= '0;
      o_TargetValue       <= '0;
      o_Overflow          <= 1'b0;
      o_Timeout           <= 1'b0;
    end else begin
      state_q             <= state_d;
      cnt_q               <= cnt_d;
      o_TargetWriteEnable <= strobe_d;
      if (fifo_pop) hold_q <= entry_t'(fifo_rd_dat);
      if (dispatch) begin
        o_TargetAddress <= hold_q.number[12:0];
        o_TargetValue   <= hold_q.value;
      end
      if (push_req && !fifo_wr_rdy) o_Overflow <= 1'b1;
      else if (i_ClearFlags)        o_Overflow <= 1'b0;
      if (timeout_evt)              o_Timeout  <= 1'b1;
      else if (i_ClearFlags)        o_Timeout  <= 1'b0;
    end
  end

  assign o_Busy = (state_q != IDLE) || (o_FifoCount != '0);
endmodule

// File: tb/tb_register_write_scheduler.sv
// Bench for register_write_scheduler: queue-level reference model checked every cycle plus directed literal checks.

module tb_register_write_scheduler;
  localparam int DEPTH = 8;
  localparam int TMO   = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [14:0] num;
  logic [15:0] val;
  logic [3:0]  rdy;
  logic        clr;
  logic [3:0]  o_stb;
  logic [12:0] o_addr;
  logic [15:0] o_val;
  logic [3:0]  o_cnt;
  logic        o_ovf, o_tmo, o_busy;

  register_write_scheduler #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .i_Clock             (clk),
    .i_Reset             (rst),
    .i_WriteEnable       (we),
    .i_WriteNumber       (num),
    .i_WriteValue        (val),
    .i_TargetReady       (rdy),
    .i_ClearFlags        (clr),
    .o_TargetWriteEnable (o_stb),
    .o_TargetAddress     (o_addr),
    .o_TargetValue       (o_val),
    .o_FifoCount         (o_cnt),
    .o_Overflow          (o_ovf),
    .o_Timeout           (o_tmo),
    .o_Busy              (o_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct packed {
    logic [14:0] number;
    logic [15:0] value;
  } ent_t;

  typedef struct packed {
    logic [3:0]  stb;
    logic [12:0] addr;
    logic [15:0] val;
  } obs_t;

  // Reference model: a plain queue of pending writes plus one entry being offered.
  ent_t        mq[$];
  ent_t        m_held;
  bit          m_holding = 0;
  int          m_age = 0;
  logic        m_last = 1'b0;
  logic [3:0]  m_stb = '0;
  logic [12:0] m_addr = '0;
  logic [15:0] m_val = '0;
  logic        m_ovf = 1'b0, m_tmo = 1'b0;
  bit          model_ok = 0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_holding = 0; m_age = 0;
      m_stb = '0; m_addr = '0; m_val = '0;
      m_ovf = 1'b0; m_tmo = 1'b0;
      m_last = we;
      model_ok = 1;
    end else if (model_ok) begin
      int  pre;
      bit  rise, ovf_set, tmo_set;
      pre = mq.size();
      rise = we && !m_last;
      m_last = we;
      ovf_set = 0; tmo_set = 0;
      m_stb = '0;
      if (m_holding) begin
        if (rdy[m_held.number[14:13]]) begin
          m_stb  = 4'b0001 << m_held.number[14:13];
          m_addr = m_held.number[12:0];
          m_val  = m_held.value;
          m_holding = 0;
        end else if (m_age == TMO - 1) begin
          m_holding = 0;
          tmo_set = 1;
        end else begin
          m_age++;
        end
      end else if (pre != 0) begin
        m_held = mq.pop_front();
        m_holding = 1;
        m_age = 0;
      end
      if (rise) begin
        if (pre == DEPTH) ovf_set = 1;
        else mq.push_back('{number: num, value: val});
      end
      m_ovf = ovf_set ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_tmo = tmo_set ? 1'b1 : (clr ? 1'b0 : m_tmo);
    end
  end

  obs_t obs[$];

  always @(negedge clk) begin
    if (o_stb != 4'b0000) obs.push_back('{stb: o_stb, addr: o_addr, val: o_val});
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("cycle",
            {24'd0, o_stb, o_addr, o_val, o_cnt, o_ovf, o_tmo, o_busy},
            {24'd0, m_stb, m_addr, m_val, 4'(mq.size()), m_ovf, m_tmo,
             logic'(m_holding || mq.size() != 0)});
    end
  end

  task automatic wr(input logic [14:0] n, input logic [15:0] v);
    num = n; val = v; we = 1'b1;
    tick(1);
    we = 1'b0;
    tick(1);
  endtask

  initial begin
    int cnt2;
    rst = 1'b1; we = 1'b0; num = '0; val = '0; rdy = 4'h0; clr = 1'b0;
    tick(3);
    check("reset_strobe", 64'(o_stb), 64'd0);
    check("reset_count",  64'(o_cnt), 64'd0);
    check("reset_busy",   64'(o_busy), 64'd0);
    check("reset_flags",  64'({o_ovf, o_tmo}), 64'd0);
    rst = 1'b0;
    tick(2);

    // Single write: strobe in cycle 3 only.
    rdy = 4'hF;
    num = 15'h2005; val = 16'hBEEF; we = 1'b1;
    tick(1);
    we = 1'b0;
    check("t1_cyc1_strobe", 64'(o_stb), 64'd0);
    tick(1);
    check("t1_cyc2_strobe", 64'(o_stb), 64'd0);
    check("t1_cyc2_busy",   64'(o_busy), 64'd1);
    tick(1);
    check("t1_cyc3_strobe", 64'(o_stb), 64'b0010);
    check("t1_cyc3_addr",   64'(o_addr), 64'h0005);
    check("t1_cyc3_value",  64'(o_val), 64'hBEEF);
    tick(1);
    check("t1_cyc4_strobe", 64'(o_stb), 64'd0);
    check("t1_cyc4_busy",   64'(o_busy), 64'd0);
    tick(2);

    // Long level gives one write; a fresh edge gives another.
    obs.delete();
    num = 15'h0011; val = 16'h1111; we = 1'b1;
    tick(20);
    we = 1'b0;
    tick(1);
    we = 1'b1;
    tick(3);
    we = 1'b0;
    tick(10);
    check("t2_strobes", 64'(obs.size()), 64'd2);
    for (int i = 0; i < 2; i++)
      if (i < obs.size()) check("t2_entry", 64'({obs[i].stb, obs[i].val}), 64'({4'b0001, 16'h1111}));

    // Ten writes with no window: one held, eight queued, the tenth dropped.
    obs.delete();
    rdy = 4'h0;
    for (int i = 0; i < 10; i++) wr(15'(i), 16'h3000 + 16'(i));
    check("t3_count",    64'(o_cnt), 64'd8);
    check("t3_overflow", 64'(o_ovf), 64'd1);
    rdy = 4'h1;
    tick(30);
    check("t3_strobes", 64'(obs.size()), 64'd9);
    for (int i = 0; i < 9; i++)
      if (i < obs.size())
        check("t3_order", 64'({obs[i].stb, obs[i].addr, obs[i].val}),
              64'({4'b0001, 13'(i), 16'h3000 + 16'(i)}));
    check("t3_drained", 64'(o_cnt), 64'd0);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("t3_clear", 64'(o_ovf), 64'd0);
    tick(2);

    // Target2 never opens and times out; the queued target1 write follows.
    obs.delete();
    rdy = 4'b0010;
    num = 15'h4007; val = 16'h4444; we = 1'b1;
    tick(1);
    we = 1'b0;
    tick(1);
    num = 15'h2009; val = 16'h5555; we = 1'b1;
    tick(1);
    we = 1'b0;
    tick(253);
    check("t4_before_timeout", 64'(o_tmo), 64'd0);
    tick(1);
    check("t4_timeout", 64'(o_tmo), 64'd1);
    tick(2);
    check("t4_next_strobe", 64'({o_stb, o_addr, o_val}), 64'({4'b0010, 13'h0009, 16'h5555}));
    tick(3);
    cnt2 = 0;
    foreach (obs[i]) if (obs[i].stb == 4'b0100) cnt2++;
    check("t4_no_target2", 64'(cnt2), 64'd0);

    // Reset during WAIT with the strobe level held across reset.
    obs.delete();
    rdy = 4'h0;
    num = 15'h0001; val = 16'h6666; we = 1'b1;
    tick(3);
    check("t5_waiting", 64'({o_busy, o_cnt}), 64'({1'b1, 4'd0}));
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    rdy = 4'hF;
    tick(5);
    check("t5_no_strobe", 64'(obs.size()), 64'd0);
    check("t5_idle", 64'({o_busy, o_cnt}), 64'd0);
    we = 1'b0;
    tick(1);
    num = 15'h0002; val = 16'h7777; we = 1'b1;
    tick(1);
    we = 1'b0;
    tick(5);
    check("t5_recapture", 64'(obs.size()), 64'd1);
    if (obs.size() > 0) check("t5_value", 64'(obs[0].val), 64'h7777);

    // Overflow set wins over a same-cycle clear; a later clear alone wins.
    rdy = 4'h0;
    for (int i = 0; i < 9; i++) wr(15'(i), 16'h6000 + 16'(i));
    check("t6_pre_ovf", 64'(o_ovf), 64'd0);
    num = 15'h0009; val = 16'h6009; we = 1'b1; clr = 1'b1;
    tick(1);
    we = 1'b0; clr = 1'b0;
    check("t6_set_wins", 64'(o_ovf), 64'd1);
    tick(2);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("t6_clear", 64'(o_ovf), 64'd0);
    rdy = 4'hF;
    tick(30);
    check("t6_drained", 64'({o_busy, o_cnt}), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
